// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver with majority-vote sampling, parity/framing flags
// and a small receive FIFO drained through a level ack / ack-clear handshake.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_uart_clk_x16,
    input  logic                          i_reset,
    input  logic                          i_uart_rx,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_data_perr,
    output logic                          o_data_ferr,
    output logic                          o_data_rdy,
    input  logic                          i_rdy_ack,
    output logic                          o_rdy_ack_clr,
    output logic                          o_overrun,
    input  logic                          i_overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_busy
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int WORD_W = DATA_BITS + 2;

    typedef enum logic [2:0] {
        ST_PENDING,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state, state_next;

    logic                 rx_meta, rx_s;
    logic [3:0]           tick;
    logic                 samp7, samp8, maj;
    logic [IDX_W-1:0]     bit_idx, bit_pos;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_data;
    logic                 perr_r, ferr_r, push_ferr;
    logic                 mid_bit, end_bit, last_data, last_stop;
    logic                 busy_now, busy_next, push;

    logic [WORD_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 ack_d, pop_req, pop, full, do_write;

    always_ff @(posedge i_uart_clk_x16) begin
        if (i_reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign maj       = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
    assign mid_bit   = (tick == 4'd9);
    assign end_bit   = (tick == 4'd15);
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    assign bit_pos   = (MSB_FIRST != 0) ? (IDX_W'(DATA_BITS - 1) - bit_idx) : bit_idx;
    assign push_ferr = ferr_r | ~maj;

    assign busy_now  = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_PARITY) || (state == ST_STOP);
    assign busy_next = (state_next == ST_START) || (state_next == ST_DATA) ||
                       (state_next == ST_PARITY) || (state_next == ST_STOP);

    // A clean stop bit returns straight to IDLE at mid-bit so back-to-back
    // frames lose no time; a bad stop waits in PENDING for the line to go high.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            ST_PENDING: if (rx_s) state_next = ST_IDLE;
            ST_IDLE:    if (!rx_s) state_next = ST_START;
            ST_START: begin
                if (mid_bit && maj)
                    state_next = ST_IDLE;
                else if (end_bit)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (end_bit && last_data)
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY:  if (end_bit) state_next = ST_STOP;
            ST_STOP: begin
                if (mid_bit && last_stop) begin
                    push       = 1'b1;
                    state_next = push_ferr ? ST_PENDING : ST_IDLE;
                end
            end
            default:    state_next = ST_PENDING;
        endcase
    end

    always_ff @(posedge i_uart_clk_x16) begin
        if (i_reset) begin
            state      <= ST_PENDING;
            tick       <= 4'd0;
            samp7      <= 1'b1;
            samp8      <= 1'b1;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_data <= '0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state <= state_next;
            tick  <= (busy_now && busy_next) ? tick + 4'd1 : 4'd0;
            if (tick == 4'd7) samp7 <= rx_s;
            if (tick == 4'd8) samp8 <= rx_s;
            if (state == ST_IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                perr_r   <= 1'b0;
                ferr_r   <= 1'b0;
            end
            if (state == ST_DATA && mid_bit) shift_data[bit_pos] <= maj;
            if (state == ST_DATA && end_bit) bit_idx <= bit_idx + IDX_W'(1);
            if (state == ST_PARITY && mid_bit)
                perr_r <= (^shift_data) ^ maj ^ (PARITY == 1);
            if (state == ST_STOP && mid_bit) ferr_r <= push_ferr;
            if (state == ST_STOP && end_bit) stop_idx <= stop_idx + 1'b1;
        end
    end

    // A pop frees the head slot, so a push into a full FIFO is accepted when
    // it coincides with a pop.
    assign pop_req  = i_rdy_ack & ~ack_d;
    assign pop      = pop_req & (count != '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign do_write = push & (~full | pop);

    always_ff @(posedge i_uart_clk_x16) begin
        if (do_write) mem[wr_ptr] <= {shift_data, perr_r, push_ferr};
    end

    always_ff @(posedge i_uart_clk_x16) begin
        if (i_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ack_d         <= 1'b0;
            o_rdy_ack_clr <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            ack_d <= i_rdy_ack;
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_write, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop_req)
                o_rdy_ack_clr <= 1'b1;
            else if (!i_rdy_ack)
                o_rdy_ack_clr <= 1'b0;
            if (push && full && !pop)
                o_overrun <= 1'b1;
            else if (i_overrun_clr)
                o_overrun <= 1'b0;
        end
    end

    assign {o_data, o_data_perr, o_data_ferr} = mem[rd_ptr];
    assign o_data_rdy   = (count != '0);
    assign o_fifo_count = count;
    assign o_busy       = busy_now;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default receiver and a 7E2 MSB-first one with a
// 2-deep FIFO, driven by directed and random frames and checked against a word-queue model.
module tb_uart_rx_fifo;
    localparam int A_DB = 8, A_PAR = 0, A_SB = 1, A_MSBF = 0, A_DEP = 4;
    localparam int B_DB = 7, B_PAR = 2, B_SB = 2, B_MSBF = 1, B_DEP = 2;
    localparam int DB   [2] = '{A_DB, B_DB};
    localparam int PAR  [2] = '{A_PAR, B_PAR};
    localparam int SB   [2] = '{A_SB, B_SB};
    localparam int MSBF [2] = '{A_MSBF, B_MSBF};
    localparam int DEP  [2] = '{A_DEP, B_DEP};

    localparam int O_DATA = 0, O_PERR = 1, O_FERR = 2, O_RDY = 3;
    localparam int O_CLR = 4, O_OVR = 5, O_CNT = 6, O_BUSY = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rxLine, ack, ovClr;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       perr0, ferr0, rdy0, clr0, ovr0, busy0;
    logic       perr1, ferr1, rdy1, clr1, ovr1, busy1;
    logic [2:0] cnt0;
    logic [1:0] cnt1;

    int testsRun    = 0;
    int testsFailed = 0;
    int mq [2][16];
    int mqLen [2];
    bit mOvr [2];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(A_DB), .PARITY(A_PAR), .STOP_BITS(A_SB),
                   .MSB_FIRST(A_MSBF), .FIFO_DEPTH(A_DEP)) dutA (
        .i_uart_clk_x16(clk), .i_reset(rst), .i_uart_rx(rxLine[0]),
        .o_data(data0), .o_data_perr(perr0), .o_data_ferr(ferr0), .o_data_rdy(rdy0),
        .i_rdy_ack(ack[0]), .o_rdy_ack_clr(clr0), .o_overrun(ovr0),
        .i_overrun_clr(ovClr[0]), .o_fifo_count(cnt0), .o_busy(busy0)
    );

    uart_rx_fifo #(.DATA_BITS(B_DB), .PARITY(B_PAR), .STOP_BITS(B_SB),
                   .MSB_FIRST(B_MSBF), .FIFO_DEPTH(B_DEP)) dutB (
        .i_uart_clk_x16(clk), .i_reset(rst), .i_uart_rx(rxLine[1]),
        .o_data(data1), .o_data_perr(perr1), .o_data_ferr(ferr1), .o_data_rdy(rdy1),
        .i_rdy_ack(ack[1]), .o_rdy_ack_clr(clr1), .o_overrun(ovr1),
        .i_overrun_clr(ovClr[1]), .o_fifo_count(cnt1), .o_busy(busy1)
    );

    function automatic int getObs(input int d, input int sel);
        if (d == 0) begin
            case (sel)
                O_DATA: return int'(data0);
                O_PERR: return int'(perr0);
                O_FERR: return int'(ferr0);
                O_RDY:  return int'(rdy0);
                O_CLR:  return int'(clr0);
                O_OVR:  return int'(ovr0);
                O_CNT:  return int'(cnt0);
                default: return int'(busy0);
            endcase
        end
        case (sel)
            O_DATA: return int'(data1);
            O_PERR: return int'(perr1);
            O_FERR: return int'(ferr1);
            O_RDY:  return int'(rdy1);
            O_CLR:  return int'(clr1);
            O_OVR:  return int'(ovr1);
            O_CNT:  return int'(cnt1);
            default: return int'(busy1);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: the FIFO is just a list of received words with a size cap.
    task automatic modelPush(input int d, input int word, input int pe, input int fe);
        if (mqLen[d] < DEP[d]) begin
            mq[d][mqLen[d]] = word | (pe << 8) | (fe << 9);
            mqLen[d]++;
        end else begin
            mOvr[d] = 1'b1;
        end
    endtask

    task automatic modelPop(input int d);
        if (mqLen[d] > 0) begin
            for (int i = 1; i < mqLen[d]; i++) mq[d][i-1] = mq[d][i];
            mqLen[d]--;
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mqLen[d] = 0;
            mOvr[d]  = 1'b0;
        end
    endtask

    task automatic checkState(input int d, input string tag);
        checkOutput({tag, "/count"}, getObs(d, O_CNT), mqLen[d]);
        checkOutput({tag, "/rdy"}, getObs(d, O_RDY), (mqLen[d] > 0) ? 1 : 0);
        checkOutput({tag, "/overrun"}, getObs(d, O_OVR), mOvr[d] ? 1 : 0);
        if (mqLen[d] > 0) begin
            checkOutput({tag, "/data"}, getObs(d, O_DATA), mq[d][0] & 'hFF);
            checkOutput({tag, "/perr"}, getObs(d, O_PERR), (mq[d][0] >> 8) & 1);
            checkOutput({tag, "/ferr"}, getObs(d, O_FERR), (mq[d][0] >> 9) & 1);
        end
    endtask

    // Line levels of one frame, one entry per bit period, start bit first.
    function automatic int buildFrame(input int d, input int word, input int badPar,
                                      input int stopMask, output logic [15:0] bits);
        int   n;
        int   ones;
        logic b;
        bits    = '1;
        bits[0] = 1'b0;
        n       = 1;
        ones    = 0;
        for (int k = 0; k < DB[d]; k++) begin
            b       = (MSBF[d] != 0) ? word[DB[d]-1-k] : word[k];
            bits[n] = b;
            ones   += int'(b);
            n++;
        end
        if (PAR[d] != 0) begin
            bits[n] = ((ones % 2) == 1) ^ (PAR[d] == 1) ^ (badPar != 0);
            n++;
        end
        for (int s = 0; s < SB[d]; s++) begin
            bits[n] = stopMask[s];
            n++;
        end
        return n;
    endfunction

    task automatic applyStimulus(input int d, input int word, input int badPar,
                                 input int stopMask, input int ackCycle, input int abortCycle);
        logic [15:0] bits;
        int          n;
        n = buildFrame(d, word, badPar, stopMask, bits);
        for (int c = 0; c < 16 * n; c++) begin
            @(negedge clk);
            rxLine[d] = bits[c / 16];
            if (c == ackCycle) ack[d] = 1'b1;
            if (c == abortCycle) begin
                rst = 1'b1;
                return;
            end
        end
    endtask

    task automatic idle(input int d, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            rxLine[d] = 1'b1;
        end
    endtask

    task automatic sendWord(input int d, input int word, input int badPar,
                            input int stopMask, input int gap, input string tag);
        int allOnes, pe, fe;
        allOnes = (1 << SB[d]) - 1;
        pe = (PAR[d] != 0 && badPar != 0) ? 1 : 0;
        fe = ((stopMask & allOnes) != allOnes) ? 1 : 0;
        applyStimulus(d, word, badPar, stopMask, -1, -1);
        modelPush(d, word, pe, fe);
        idle(d, gap);
        checkState(d, tag);
    endtask

    task automatic ackPulse(input int d, input string tag);
        @(negedge clk);
        ack[d] = 1'b1;
        @(negedge clk);
        modelPop(d);
        checkOutput({tag, "/ackclr"}, getObs(d, O_CLR), 1);
        checkState(d, tag);
        ack[d] = 1'b0;
        @(negedge clk);
        checkOutput({tag, "/ackclr_drop"}, getObs(d, O_CLR), 0);
    endtask

    task automatic clearOverrun(input int d, input string tag);
        @(negedge clk);
        ovClr[d] = 1'b1;
        @(negedge clk);
        ovClr[d] = 1'b0;
        mOvr[d]  = 1'b0;
        checkState(d, tag);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed no completion, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int w [5];

        rst    = 1'b1;
        rxLine = 2'b11;
        ack    = 2'b00;
        ovClr  = 2'b00;
        modelReset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkState(d, "reset");
            checkOutput("reset/busy", getObs(d, O_BUSY), 0);
            checkOutput("reset/ackclr", getObs(d, O_CLR), 0);
        end
        rst = 1'b0;
        idle(0, 8);

        // Two words queued, then a held ack pops exactly one.
        sendWord(0, 'h55, 0, 1, 3, "w55");
        sendWord(0, 'hA3, 0, 1, 3, "wA3");
        @(negedge clk);
        ack[0] = 1'b1;
        @(negedge clk);
        modelPop(0);
        checkState(0, "ackA3");
        checkOutput("ackA3/ackclr", getObs(0, O_CLR), 1);
        repeat (3) @(negedge clk);
        checkOutput("ackhold/ackclr", getObs(0, O_CLR), 1);
        checkState(0, "ackhold");
        ack[0] = 1'b0;
        @(negedge clk);
        checkOutput("ackdrop/ackclr", getObs(0, O_CLR), 0);
        ackPulse(0, "drain1");
        ackPulse(0, "emptypop");

        // Even parity, good then bad parity bit.
        sendWord(1, 'h07, 0, 3, 3, "par_ok");
        sendWord(1, 'h07, 1, 3, 3, "par_bad");
        ackPulse(1, "par_pop1");
        ackPulse(1, "par_pop2");

        // 5-cycle glitch must be rejected as a false start.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rxLine[0] = (c < 5) ? 1'b0 : 1'b1;
            if (c == 8)  checkOutput("glitch/busy_hi", getObs(0, O_BUSY), 1);
            if (c == 13) checkOutput("glitch/busy_lo", getObs(0, O_BUSY), 0);
        end
        checkState(0, "glitch");
        sendWord(0, 'h3C, 0, 1, 3, "w3C");
        ackPulse(0, "pop3C");

        // Framing error followed by a held-low line.
        applyStimulus(0, 'h81, 0, 0, -1, -1);
        modelPush(0, 'h81, 0, 1);
        repeat (16) begin
            @(negedge clk);
            rxLine[0] = 1'b0;
        end
        idle(0, 32);
        checkState(0, "ferr81");
        sendWord(0, 'h96, 0, 1, 3, "after_ferr");
        ackPulse(0, "popferr1");
        ackPulse(0, "popferr2");

        // Five words into a 4-deep FIFO without ack: last one dropped.
        for (int i = 0; i < 5; i++) begin
            w[i] = $urandom_range(0, 255);
            sendWord(0, w[i], 0, 1, 2, $sformatf("fill%0d", i));
        end
        clearOverrun(0, "ovclr");
        for (int i = 0; i < 4; i++) ackPulse(0, $sformatf("drainA%0d", i));

        // Same again, with the ack edge landing on the fifth push cycle.
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom_range(0, 255);
            sendWord(0, w[i], 0, 1, 2, $sformatf("refill%0d", i));
        end
        w[4] = $urandom_range(0, 255);
        applyStimulus(0, w[4], 0, 1, 16 * 10 - 4, -1);
        modelPop(0);
        modelPush(0, w[4], 0, 0);
        checkState(0, "pushpop_full");
        checkOutput("pushpop_full/ackclr", getObs(0, O_CLR), 1);
        ack[0] = 1'b0;
        idle(0, 2);
        checkOutput("pushpop_full/ackclr_drop", getObs(0, O_CLR), 0);
        for (int i = 0; i < 4; i++) ackPulse(0, $sformatf("drainB%0d", i));

        // Reset in the middle of data bit 3 discards everything.
        sendWord(0, 'h44, 0, 1, 2, "pre_reset");
        applyStimulus(0, 'h5A, 0, 1, -1, 16 * 4 + 8);
        checkOutput("midframe/busy", getObs(0, O_BUSY), 1);
        rxLine[0] = 1'b1;
        repeat (2) @(negedge clk);
        modelReset();
        checkState(0, "midreset");
        checkOutput("midreset/busy", getObs(0, O_BUSY), 0);
        rst = 1'b0;
        idle(0, 20);
        sendWord(0, 'h12, 0, 1, 3, "w12");
        ackPulse(0, "pop12");

        // Random traffic on both receivers.
        for (int i = 0; i < 40; i++) begin
            int d, word, bp, sm, gap;
            d    = $urandom_range(0, 1);
            word = $urandom_range(0, (1 << DB[d]) - 1);
            bp   = (PAR[d] != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            sm   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (1 << SB[d]) - 2)
                                               : (1 << SB[d]) - 1;
            gap  = (sm != (1 << SB[d]) - 1) ? 24 + $urandom_range(0, 8) : $urandom_range(0, 6);
            sendWord(d, word, bp, sm, gap, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) ackPulse(d, $sformatf("rndack%0d", i));
            if ($urandom_range(0, 5) == 0) clearOverrun(d, $sformatf("rndclr%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the single-byte UART receiver, clocked from the 16x oversample clock.
- Configurable data width, parity, stop bits and bit order.
- Majority-vote sampling with false-start rejection.
- Per-word parity and framing error flags.
- Small receive FIFO so the CPU-side consumer can fall several words behind without loss.
- Keeps the level ack / ack-clear handshake toward the bus/IO-port logic.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal 1 or 2.
- MSB_FIRST, 0, 0 = LSB received first (standard), 1 = MSB received first.
- FIFO_DEPTH, 4, receive FIFO entries, power of 2, 2..16.

Ports:
- i_uart_clk_x16  in  1  sole clock, 16x baud rate.
- i_reset  in  1  synchronous, active-high reset.
- i_uart_rx  in  1  asynchronous serial line, idle high.
- o_data  out  DATA_BITS  FIFO head word; valid only while o_data_rdy = 1.
- o_data_perr  out  1  parity error flag of the head word; 0 when PARITY = 0.
- o_data_ferr  out  1  framing error flag of the head word.
- o_data_rdy  out  1  FIFO non-empty.
- i_rdy_ack  in  1  level ack from the consumer; its rising edge pops one word.
- o_rdy_ack_clr  out  1  pop acknowledged; stays high until i_rdy_ack falls.
- o_overrun  out  1  sticky: a word was dropped because the FIFO was full.
- i_overrun_clr  in  1  clears o_overrun.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words held.
- o_busy  out  1  receiver is in START, DATA, PARITY or STOP.

Behaviour:
- Reset values: o_data_rdy = 0, o_rdy_ack_clr = 0, o_overrun = 0, o_fifo_count = 0, o_busy = 0.
- Reset also: FIFO pointers = 0, state = PENDING. o_data, o_data_perr and o_data_ferr are don't-care while empty.
- Reset mid-frame aborts the frame; no partial word is ever pushed. Reset has priority over every other event.
- Synchroniser: i_uart_rx passes through two flops to give rx_s. All decisions use rx_s.
- Tick counter: 4 bits, runs 0..15 within each bit period. It is cleared to 0 on entry to START.
- Sampling: samples are taken at ticks 7, 8 and 9. The bit value is the 2-of-3 majority, decided at tick 9.
- States:
  - PENDING: wait for rx_s = 1, then go to IDLE.
  - IDLE: on rx_s = 0, go to START with tick = 0.
  - START: at tick 9, majority 1 means a false start: return to IDLE, push nothing. Majority 0 continues.
  - START: at tick 15, go to DATA with bit index = 0.
  - DATA: shift in DATA_BITS bits, one per period. Bit k lands at position k when MSB_FIRST = 0, else at position DATA_BITS-1-k.
  - DATA: after the last bit's tick 15, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: perr = (XOR of data bits XOR parity bit) != (PARITY == 1 ? 1 : 0).
  - STOP: each stop bit is sampled by majority. ferr = 1 if any stop bit majority is 0.
  - STOP, final stop bit, tick 9: push {data, perr, ferr}.
  - STOP, after the push: if ferr = 0, go to IDLE in the same cycle, so the next start edge is caught without a half-bit gap. If ferr = 1, go to PENDING (break or line low).
- Push-to-visible latency: the word, its flags and o_data_rdy appear the cycle after the push. o_fifo_count updates the same cycle.
- Pop: asserted when i_rdy_ack is 1 this cycle and was 0 last cycle (edge detect register, reset to 0).
  - On pop: o_rdy_ack_clr <= 1 and the read pointer advances if the FIFO is non-empty.
  - o_rdy_ack_clr <= 0 in the first cycle i_rdy_ack is seen low.
  - A pop while empty has no effect on the FIFO, but o_rdy_ack_clr still handshakes.
- Full:
  - Push while full and no pop: the word is dropped and o_overrun <= 1.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
- Empty: push and pop in the same cycle while empty: push only, count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. The count range is 0..FIFO_DEPTH.
- i_overrun_clr in the same cycle as a new overrun: set wins.

Test Plan:
- Defaults. Send 0x55, then 0xA3, at 16 ticks/bit, no ack. Required: o_fifo_count = 2, o_data = 0x55, perr = ferr = 0. Ack rising edge: o_data = 0xA3 next cycle, o_rdy_ack_clr high until ack drops.
- PARITY = 2. Send 0x07 with parity bit 1 (correct): perr = 0. Resend 0x07 with parity bit 0: perr = 1. Data = 0x07 both times.
- Pulse rx low for 5 ticks from idle. Required: no push, state returns to IDLE, o_busy falls by tick 10. A following valid 0x3C frame is received correctly.
- Send 0x81 with stop bit forced 0, then the line returns high for 2 bits. Required: ferr = 1 on 0x81. The next frame is received only after the line goes high.
- FIFO_DEPTH = 4. Send 5 words with no ack: count = 4, o_overrun = 1, head = first word. Repeat with ack pulsed at the 5th push cycle: no overrun.
- Assert i_reset during DATA bit 3, then send 0x12. Required: only 0x12 is in the FIFO, count = 1, all flags cleared.
